// File: rtl/grp_pingpong_if.sv
// Handshake and bank-port bundle between the ping-pong controller, the
// frame filler (writer), the M8 frame former (reader) and the two group
// buffers. The controller sits on the slave side; the environment
// (writer/reader/buffers) sits on the master side.
interface grp_pingpong_if #(
    parameter int DATA_W = 12,
    parameter int CNT_W  = 16
);
    // writer side
    logic              wr_req;
    logic              wr_done;
    logic              wr_en_in;
    logic              wr_grant;
    logic              wr_bank;
    // reader side
    logic              rd_req;
    logic              rd_done;
    logic              rd_en_in;
    logic              rd_grant;
    logic              rd_bank;
    logic [DATA_W-1:0] rd_data;
    // group buffer ports
    logic [DATA_W-1:0] m0_q;
    logic [DATA_W-1:0] m1_q;
    logic              m0_we;
    logic              m1_we;
    logic              m0_re;
    logic              m1_re;
    // status
    logic              underrun;
    logic              overrun;
    logic [CNT_W-1:0]  underrun_cnt;
    logic [CNT_W-1:0]  overrun_cnt;
    logic              proto_err;

    modport master (
        output wr_req, wr_done, wr_en_in,
        output rd_req, rd_done, rd_en_in,
        output m0_q, m1_q,
        input  wr_grant, wr_bank, rd_grant, rd_bank, rd_data,
        input  m0_we, m1_we, m0_re, m1_re,
        input  underrun, overrun, underrun_cnt, overrun_cnt, proto_err
    );

    modport slave (
        input  wr_req, wr_done, wr_en_in,
        input  rd_req, rd_done, rd_en_in,
        input  m0_q, m1_q,
        output wr_grant, wr_bank, rd_grant, rd_bank, rd_data,
        output m0_we, m1_we, m0_re, m1_re,
        output underrun, overrun, underrun_cnt, overrun_cnt, proto_err
    );
endinterface

// File: rtl/grp_pingpong_ctrl.sv
// Ping-pong arbitration for the two group buffers (m0/m1).
// Each bank carries its own FREE/WRITING/READY/READING state. Writer and
// reader obtain banks through request/grant handshakes; a read request that
// finds nothing READY starts a zero-fill session so the reader never sees
// stale or half-written data. Events within one cycle are applied in the
// order wr_done, rd_done, rd_req, wr_req so completions and releases are
// visible to requests arriving in the same cycle.
module grp_pingpong_ctrl #(
    parameter int DATA_W = 12,
    parameter int CNT_W  = 16
) (
    input  logic           clk,
    input  logic           reset,
    grp_pingpong_if.slave  bus
);
    localparam logic [1:0] ST_FREE    = 2'd0;
    localparam logic [1:0] ST_WRITING = 2'd1;
    localparam logic [1:0] ST_READY   = 2'd2;
    localparam logic [1:0] ST_READING = 2'd3;

    localparam logic [DATA_W-1:0] ZERO_DATA = '0;
    localparam logic [CNT_W-1:0]  CNT_MAX   = '1;

    logic [1:0]       state_reg [2];
    logic [1:0]       state_next [2];
    logic             last_written_reg, last_written_next;
    logic             oldest_reg, oldest_next;      // oldest READY bank when both are READY
    logic             rd_zero_reg, rd_zero_next;
    logic             wr_bank_reg, wr_bank_next;
    logic             rd_bank_reg, rd_bank_next;
    logic             wr_grant_reg, wr_grant_next;
    logic             rd_grant_reg, rd_grant_next;
    logic             underrun_reg, underrun_next;
    logic             overrun_reg, overrun_next;
    logic             proto_err_reg, proto_err_next;
    logic [CNT_W-1:0] underrun_cnt_reg, underrun_cnt_next;
    logic [CNT_W-1:0] overrun_cnt_reg, overrun_cnt_next;

    logic             bank_we [2];
    logic             bank_re [2];

    // Next-state evaluation: apply this cycle's events in priority order.
    always_comb begin
        for (int i = 0; i < 2; i++) begin
            state_next[i] = state_reg[i];
        end
        last_written_next = last_written_reg;
        oldest_next       = oldest_reg;
        rd_zero_next      = rd_zero_reg;
        wr_bank_next      = wr_bank_reg;
        rd_bank_next      = rd_bank_reg;
        wr_grant_next     = 1'b0;
        rd_grant_next     = 1'b0;
        underrun_next     = 1'b0;
        overrun_next      = 1'b0;
        proto_err_next    = 1'b0;
        underrun_cnt_next = underrun_cnt_reg;
        overrun_cnt_next  = overrun_cnt_reg;

        // Writer completion: the WRITING bank is always the one last granted.
        if (bus.wr_done) begin
            if (state_next[wr_bank_reg] == ST_WRITING) begin
                state_next[wr_bank_reg] = ST_READY;
                last_written_next       = wr_bank_reg;
                // If the other bank is already READY it stays the oldest.
                oldest_next = (state_next[~wr_bank_reg] == ST_READY) ? ~wr_bank_reg : wr_bank_reg;
            end else begin
                proto_err_next = 1'b1;
            end
        end

        // Reader release: a zero-fill session only clears its flag.
        if (bus.rd_done) begin
            if (rd_zero_next) begin
                rd_zero_next = 1'b0;
            end else if (state_next[rd_bank_reg] == ST_READING) begin
                state_next[rd_bank_reg] = ST_FREE;
            end else begin
                proto_err_next = 1'b1;
            end
        end

        // Reader request: oldest READY bank, otherwise start zero-fill.
        if (bus.rd_req) begin
            if (state_next[0] == ST_READING || state_next[1] == ST_READING || rd_zero_next) begin
                proto_err_next = 1'b1;
            end else if (state_next[0] == ST_READY || state_next[1] == ST_READY) begin
                if (state_next[0] == ST_READY && state_next[1] == ST_READY) begin
                    rd_bank_next = oldest_next;
                end else begin
                    rd_bank_next = (state_next[1] == ST_READY);
                end
                state_next[rd_bank_next] = ST_READING;
                rd_grant_next            = 1'b1;
            end else begin
                underrun_next = 1'b1;
                rd_zero_next  = 1'b1;
                if (underrun_cnt_reg != CNT_MAX) begin
                    underrun_cnt_next = underrun_cnt_reg + CNT_W'(1);
                end
            end
        end

        // Writer request: a FREE bank, preferring the one not written last.
        if (bus.wr_req) begin
            if (state_next[0] == ST_WRITING || state_next[1] == ST_WRITING) begin
                proto_err_next = 1'b1;
            end else if (state_next[0] == ST_FREE || state_next[1] == ST_FREE) begin
                if (state_next[0] == ST_FREE && state_next[1] == ST_FREE) begin
                    wr_bank_next = ~last_written_next;
                end else begin
                    wr_bank_next = (state_next[1] == ST_FREE);
                end
                state_next[wr_bank_next] = ST_WRITING;
                wr_grant_next            = 1'b1;
            end else begin
                overrun_next = 1'b1;
                if (overrun_cnt_reg != CNT_MAX) begin
                    overrun_cnt_next = overrun_cnt_reg + CNT_W'(1);
                end
            end
        end
    end

    // State registers; reset also kills any grant pulse in flight.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 2; i++) begin
                state_reg[i] <= ST_FREE;
            end
            last_written_reg <= 1'b1;
            oldest_reg       <= 1'b0;
            rd_zero_reg      <= 1'b0;
            wr_bank_reg      <= 1'b0;
            rd_bank_reg      <= 1'b0;
            wr_grant_reg     <= 1'b0;
            rd_grant_reg     <= 1'b0;
            underrun_reg     <= 1'b0;
            overrun_reg      <= 1'b0;
            proto_err_reg    <= 1'b0;
            underrun_cnt_reg <= '0;
            overrun_cnt_reg  <= '0;
        end else begin
            for (int i = 0; i < 2; i++) begin
                state_reg[i] <= state_next[i];
            end
            last_written_reg <= last_written_next;
            oldest_reg       <= oldest_next;
            rd_zero_reg      <= rd_zero_next;
            wr_bank_reg      <= wr_bank_next;
            rd_bank_reg      <= rd_bank_next;
            wr_grant_reg     <= wr_grant_next;
            rd_grant_reg     <= rd_grant_next;
            underrun_reg     <= underrun_next;
            overrun_reg      <= overrun_next;
            proto_err_reg    <= proto_err_next;
            underrun_cnt_reg <= underrun_cnt_next;
            overrun_cnt_reg  <= overrun_cnt_next;
        end
    end

    // Per-bank enables gated by bank state; reads are blocked during zero-fill.
    for (genvar gi = 0; gi < 2; gi++) begin : g_bank_en
        assign bank_we[gi] = bus.wr_en_in & (state_reg[gi] == ST_WRITING);
        assign bank_re[gi] = bus.rd_en_in & (state_reg[gi] == ST_READING) & ~rd_zero_reg;
    end

    assign bus.m0_we = bank_we[0];
    assign bus.m1_we = bank_we[1];
    assign bus.m0_re = bank_re[0];
    assign bus.m1_re = bank_re[1];

    assign bus.rd_data = rd_zero_reg ? ZERO_DATA : (rd_bank_reg ? bus.m1_q : bus.m0_q);

    assign bus.wr_grant     = wr_grant_reg;
    assign bus.wr_bank      = wr_bank_reg;
    assign bus.rd_grant     = rd_grant_reg;
    assign bus.rd_bank      = rd_bank_reg;
    assign bus.underrun     = underrun_reg;
    assign bus.overrun      = overrun_reg;
    assign bus.underrun_cnt = underrun_cnt_reg;
    assign bus.overrun_cnt  = overrun_cnt_reg;
    assign bus.proto_err    = proto_err_reg;
endmodule

// File: tb/tb_grp_pingpong_ctrl.sv
// Directed bench for grp_pingpong_ctrl. Inputs change on the falling edge;
// registered outputs are checked on the falling edge after the rising edge
// that consumed the inputs, combinational outputs #1 after an input change.
module tb_grp_pingpong_ctrl;
    logic clk;
    logic reset;
    int   checks;
    int   errors;
    int   m0_we_cnt;
    int   m1_we_cnt;
    logic exp_last;
    logic exp_bank;

    grp_pingpong_if #(.DATA_W(12), .CNT_W(16)) bus ();

    grp_pingpong_ctrl #(.DATA_W(12), .CNT_W(16)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    initial begin
        checks       = 0;
        errors       = 0;
        reset        = 1'b1;
        bus.wr_req   = 1'b0;
        bus.wr_done  = 1'b0;
        bus.wr_en_in = 1'b0;
        bus.rd_req   = 1'b0;
        bus.rd_done  = 1'b0;
        bus.rd_en_in = 1'b0;
        bus.m0_q     = 12'h111;
        bus.m1_q     = 12'h222;
        tick();
        tick();
        reset = 1'b0;
        tick();

        // Reset state
        check("rst_wr_bank", bus.wr_bank, 0);
        check("rst_rd_bank", bus.rd_bank, 0);
        check("rst_wr_grant", bus.wr_grant, 0);
        check("rst_rd_grant", bus.rd_grant, 0);
        check("rst_ur_cnt", bus.underrun_cnt, 0);
        check("rst_or_cnt", bus.overrun_cnt, 0);
        check("rst_proto", bus.proto_err, 0);
        check("rst_rd_data", bus.rd_data, 12'h111);

        // Basic write into bank 0 then read it back
        bus.wr_req = 1'b1; tick(); bus.wr_req = 1'b0;
        check("t1_wr_grant", bus.wr_grant, 1);
        check("t1_wr_bank", bus.wr_bank, 0);
        tick();
        check("t1_wr_grant_end", bus.wr_grant, 0);
        m0_we_cnt = 0;
        m1_we_cnt = 0;
        for (int i = 0; i < 5; i++) begin
            bus.wr_en_in = 1'b1;
            #1;
            if (bus.m0_we === 1'b1) m0_we_cnt++;
            if (bus.m1_we === 1'b1) m1_we_cnt++;
            tick();
        end
        bus.wr_en_in = 1'b0;
        check("t1_m0_we_cnt", m0_we_cnt, 5);
        check("t1_m1_we_cnt", m1_we_cnt, 0);
        bus.wr_done = 1'b1; tick(); bus.wr_done = 1'b0;
        bus.rd_req = 1'b1; tick(); bus.rd_req = 1'b0;
        check("t1_rd_grant", bus.rd_grant, 1);
        check("t1_rd_bank", bus.rd_bank, 0);
        check("t1_underrun", bus.underrun, 0);
        bus.rd_en_in = 1'b1;
        #1;
        check("t1_m0_re", bus.m0_re, 1);
        check("t1_m1_re", bus.m1_re, 0);
        check("t1_rd_data", bus.rd_data, 12'h111);
        bus.m0_q = 12'h5A5;
        #1;
        check("t1_rd_data_follow", bus.rd_data, 12'h5A5);
        bus.rd_en_in = 1'b0;
        tick();
        bus.rd_done = 1'b1; tick(); bus.rd_done = 1'b0;
        check("t1_proto", bus.proto_err, 0);
        exp_last = 1'b0;

        // Steady ping-pong: each write goes to the bank not written last
        for (int g = 0; g < 8; g++) begin
            exp_bank = ~exp_last;
            bus.wr_req = 1'b1; tick(); bus.wr_req = 1'b0;
            check("pp_wr_grant", bus.wr_grant, 1);
            check("pp_wr_bank", bus.wr_bank, exp_bank);
            check("pp_overrun", bus.overrun, 0);
            bus.wr_done = 1'b1; tick(); bus.wr_done = 1'b0;
            exp_last = exp_bank;
            bus.rd_req = 1'b1; tick(); bus.rd_req = 1'b0;
            check("pp_rd_grant", bus.rd_grant, 1);
            check("pp_rd_bank", bus.rd_bank, exp_bank);
            check("pp_underrun", bus.underrun, 0);
            bus.rd_done = 1'b1; tick(); bus.rd_done = 1'b0;
            check("pp_proto", bus.proto_err, 0);
        end
        check("pp_ur_cnt", bus.underrun_cnt, 0);
        check("pp_or_cnt", bus.overrun_cnt, 0);

        // Underrun: nothing READY, reader gets zeroes until rd_done
        bus.rd_req = 1'b1; tick(); bus.rd_req = 1'b0;
        check("ur_pulse", bus.underrun, 1);
        check("ur_cnt", bus.underrun_cnt, 1);
        check("ur_rd_grant", bus.rd_grant, 0);
        tick();
        check("ur_pulse_end", bus.underrun, 0);
        bus.m0_q = 12'hABC;
        bus.rd_en_in = 1'b1;
        #1;
        check("ur_rd_data", bus.rd_data, 0);
        check("ur_m0_re", bus.m0_re, 0);
        check("ur_m1_re", bus.m1_re, 0);
        bus.rd_en_in = 1'b0;
        tick();
        bus.rd_done = 1'b1; tick(); bus.rd_done = 1'b0;
        check("ur_done_proto", bus.proto_err, 0);
        check("ur_rd_data_after", bus.rd_data, 12'hABC);

        // Overrun: both banks READY, third write request is refused
        bus.wr_req = 1'b1; tick(); bus.wr_req = 1'b0;
        check("or_fill1_bank", bus.wr_bank, 1);
        bus.wr_done = 1'b1; tick(); bus.wr_done = 1'b0;
        bus.wr_req = 1'b1; tick(); bus.wr_req = 1'b0;
        check("or_fill2_bank", bus.wr_bank, 0);
        bus.wr_done = 1'b1; tick(); bus.wr_done = 1'b0;
        bus.wr_req = 1'b1; tick(); bus.wr_req = 1'b0;
        check("or_pulse", bus.overrun, 1);
        check("or_cnt", bus.overrun_cnt, 1);
        check("or_wr_grant", bus.wr_grant, 0);
        check("or_proto", bus.proto_err, 0);
        // Drain: oldest READY (bank 1) is read first
        bus.rd_req = 1'b1; tick(); bus.rd_req = 1'b0;
        check("or_drain1_bank", bus.rd_bank, 1);
        bus.rd_done = 1'b1; tick(); bus.rd_done = 1'b0;
        bus.rd_req = 1'b1; tick(); bus.rd_req = 1'b0;
        check("or_drain2_bank", bus.rd_bank, 0);
        bus.rd_done = 1'b1; tick(); bus.rd_done = 1'b0;

        // wr_done and rd_req together: completing bank is granted directly
        bus.wr_req = 1'b1; tick(); bus.wr_req = 1'b0;
        check("sim_wr_bank", bus.wr_bank, 1);
        bus.wr_done = 1'b1; bus.rd_req = 1'b1; tick(); bus.wr_done = 1'b0; bus.rd_req = 1'b0;
        check("sim_rd_grant", bus.rd_grant, 1);
        check("sim_rd_bank", bus.rd_bank, 1);
        check("sim_no_underrun", bus.underrun, 0);
        // Bank 0 written to READY while bank 1 is READING: both busy
        bus.wr_req = 1'b1; tick(); bus.wr_req = 1'b0;
        check("sim_wr0_bank", bus.wr_bank, 0);
        bus.wr_done = 1'b1; tick(); bus.wr_done = 1'b0;
        // rd_done and wr_req together: freed bank 1 is granted
        bus.rd_done = 1'b1; bus.wr_req = 1'b1; tick(); bus.rd_done = 1'b0; bus.wr_req = 1'b0;
        check("sim_free_wr_grant", bus.wr_grant, 1);
        check("sim_free_wr_bank", bus.wr_bank, 1);
        check("sim_free_overrun", bus.overrun, 0);
        check("sim_or_cnt", bus.overrun_cnt, 1);

        // Protocol error: second rd_req in a read session
        bus.rd_req = 1'b1; tick(); bus.rd_req = 1'b0;
        check("pe_rd_grant", bus.rd_grant, 1);
        check("pe_rd_bank", bus.rd_bank, 0);
        bus.rd_req = 1'b1; tick(); bus.rd_req = 1'b0;
        check("pe_proto", bus.proto_err, 1);
        check("pe_no_grant", bus.rd_grant, 0);
        check("pe_rd_bank_hold", bus.rd_bank, 0);
        tick();
        check("pe_proto_end", bus.proto_err, 0);
        // wr_req while bank 1 is WRITING is also a protocol error
        bus.wr_req = 1'b1; tick(); bus.wr_req = 1'b0;
        check("pe_wr_proto", bus.proto_err, 1);
        check("pe_wr_no_grant", bus.wr_grant, 0);

        // Reset mid-write: everything returns to the reset state at once
        bus.wr_en_in = 1'b1;
        #1;
        check("mr_m1_we_before", bus.m1_we, 1);
        reset = 1'b1;
        #1;
        check("mr_m1_we_after", bus.m1_we, 0);
        check("mr_wr_bank", bus.wr_bank, 0);
        check("mr_rd_bank", bus.rd_bank, 0);
        check("mr_or_cnt", bus.overrun_cnt, 0);
        bus.wr_en_in = 1'b0;
        tick();
        reset = 1'b0;
        tick();
        bus.wr_req = 1'b1; tick(); bus.wr_req = 1'b0;
        check("mr_wr_grant", bus.wr_grant, 1);
        check("mr_wr_bank_regrant", bus.wr_bank, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
